// File: rtl/mixer_n.sv
// N-channel time-multiplexed audio mixer: snapshots all voices on a sample_clock
// rise, accumulates vol-scaled samples through one multiplier, emits a saturated mix.
module mixer_n #(
   parameter int BITDEPTH = 14,
   parameter int CHANNELS = 4,
   parameter int VOLBITS  = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sample_clock,
   input  logic [CHANNELS*BITDEPTH-1:0] in,
   input  logic [CHANNELS*VOLBITS-1:0]  vol,
   input  logic [CHANNELS-1:0]          mute,
   output logic [BITDEPTH-1:0]          mix,
   output logic                         mix_valid,
   output logic                         clip,
   output logic                         busy
);

   localparam int A  = BITDEPTH + VOLBITS + $clog2(CHANNELS) + 1;
   localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic signed [A-1:0] SAT_HI = A'((2 ** (BITDEPTH - 1)) - 1);
   localparam logic signed [A-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

   state_t                        state_q, state_d;
   logic                          sc_q, sc_d;
   logic [CHANNELS*BITDEPTH-1:0]  in_q, in_d;
   logic [CHANNELS*VOLBITS-1:0]   vol_q, vol_d;
   logic [CHANNELS-1:0]           mute_q, mute_d;
   logic signed [A-1:0]           acc_q, acc_d;
   logic [IW-1:0]                 idx_q, idx_d;
   logic [BITDEPTH-1:0]           mix_q, mix_d;
   logic                          clip_q, clip_d;
   logic                          mix_valid_q, mix_valid_d;

   logic                          start;
   logic [BITDEPTH-1:0]           s_raw;
   logic signed [BITDEPTH-1:0]    s_sel;
   logic signed [A-1:0]           s_ext, v_ext, prod, r, r_sat;

   always_comb begin
      state_d     = state_q;
      sc_d        = sample_clock;
      in_d        = in_q;
      vol_d       = vol_q;
      mute_d      = mute_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      mix_d       = mix_q;
      clip_d      = clip_q;
      mix_valid_d = 1'b0;

      // offset-binary to two's complement is just an MSB flip
      s_raw = in_q[idx_q*BITDEPTH +: BITDEPTH];
      s_sel = {~s_raw[BITDEPTH-1], s_raw[BITDEPTH-2:0]};
      s_ext = A'(s_sel);
      v_ext = A'({1'b0, vol_q[idx_q*VOLBITS +: VOLBITS]});
      prod  = mute_q[idx_q] ? '0 : s_ext * v_ext;

      r = acc_q >>> VOLBITS;
      if (r > SAT_HI)      r_sat = SAT_HI;
      else if (r < SAT_LO) r_sat = SAT_LO;
      else                 r_sat = r;

      start = sample_clock & ~sc_q & (state_q == S_IDLE);

      case (state_q)
         S_IDLE: if (start) begin
            in_d    = in;
            vol_d   = vol;
            mute_d  = mute;
            acc_d   = '0;
            idx_d   = '0;
            state_d = S_ACC;
         end
         S_ACC: begin
            acc_d = acc_q + prod;
            idx_d = idx_q + IW'(1);
            if (idx_q == IW'(CHANNELS - 1)) state_d = S_OUT;
         end
         S_OUT: begin
            mix_d       = {~r_sat[BITDEPTH-1], r_sat[BITDEPTH-2:0]};
            clip_d      = (r_sat != r);
            mix_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sc_q        <= 1'b0;
         in_q        <= '0;
         vol_q       <= '0;
         mute_q      <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         mix_q       <= {1'b1, {(BITDEPTH-1){1'b0}}};
         clip_q      <= 1'b0;
         mix_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sc_q        <= sc_d;
         in_q        <= in_d;
         vol_q       <= vol_d;
         mute_q      <= mute_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         mix_q       <= mix_d;
         clip_q      <= clip_d;
         mix_valid_q <= mix_valid_d;
      end
   end

   assign mix       = mix_q;
   assign clip      = clip_q;
   assign mix_valid = mix_valid_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mixer_n.sv
// Randomized + directed bench for mixer_n against an integer-arithmetic mix model.
module tb_mixer_n;
   localparam int B = 14;
   localparam int C = 4;
   localparam int V = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             sample_clock = 1'b0;
   logic [C*B-1:0]   in_v = '0;
   logic [C*V-1:0]   vol_v = '0;
   logic [C-1:0]     mute_v = '0;
   logic [B-1:0]     mix;
   logic             mix_valid, clip, busy;

   int n_chk = 0;
   int n_err = 0;

   mixer_n #(.BITDEPTH(B), .CHANNELS(C), .VOLBITS(V)) dut (
      .clk(clk), .rst(rst), .sample_clock(sample_clock),
      .in(in_v), .vol(vol_v), .mute(mute_v),
      .mix(mix), .mix_valid(mix_valid), .clip(clip), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: centre each sample on 2^(B-1), scale by vol/2^V, floor, clamp.
   function automatic void model(input logic [C*B-1:0] fi, input logic [C*V-1:0] fv,
                                 input logic [C-1:0] fm, output int em, output int ec);
      longint sum = 0;
      longint r;
      for (int ch = 0; ch < C; ch++)
         if (!fm[ch])
            sum += longint'(int'(fi[ch*B +: B]) - 2 ** (B - 1)) * longint'(fv[ch*V +: V]);
      if (sum >= 0) r = sum / (2 ** V);
      else          r = -((-sum + (2 ** V) - 1) / (2 ** V));
      ec = 0;
      if (r > 2 ** (B - 1) - 1) begin r = 2 ** (B - 1) - 1; ec = 1; end
      if (r < -(2 ** (B - 1)))  begin r = -(2 ** (B - 1));  ec = 1; end
      em = int'(r) + 2 ** (B - 1);
   endfunction

   function automatic logic [C*B-1:0] rnd_in();
      logic [C*B-1:0] v;
      for (int ch = 0; ch < C; ch++) v[ch*B +: B] = B'($urandom_range(0, 2 ** B - 1));
      return v;
   endfunction

   function automatic logic [C*V-1:0] rnd_vol();
      logic [C*V-1:0] v;
      for (int ch = 0; ch < C; ch++) v[ch*V +: V] = V'($urandom_range(0, 2 ** V - 1));
      return v;
   endfunction

   // One sample: rise sample_clock, watch 12 cycles; optionally retrigger and
   // scramble inputs while the block is accumulating.
   task automatic do_sample(input string tag, input logic [C*B-1:0] i_in,
                            input logic [C*V-1:0] i_vol, input logic [C-1:0] i_mute,
                            input bit disturb);
      int em, ec, nbusy, nvalid, vpos;
      model(i_in, i_vol, i_mute, em, ec);
      nbusy = 0; nvalid = 0; vpos = 0;
      @(negedge clk);
      in_v = i_in; vol_v = i_vol; mute_v = i_mute;
      sample_clock = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (busy) nbusy++;
         if (mix_valid) begin
            nvalid++;
            vpos = k;
            chk({tag, ".mix"}, int'(mix), em);
            chk({tag, ".clip"}, int'(clip), ec);
         end
         if (k == 1) sample_clock = 1'b0;
         if (disturb && k == 2) begin
            sample_clock = 1'b1;
            in_v = rnd_in(); vol_v = rnd_vol(); mute_v = C'($urandom);
         end
         if (disturb && k == 3) sample_clock = 1'b0;
      end
      chk({tag, ".nvalid"}, nvalid, 1);
      chk({tag, ".vpos"}, vpos, C + 2);
      chk({tag, ".nbusy"}, nbusy, C + 1);
      chk({tag, ".hold"}, int'(mix), em);
   endtask

   initial begin
      int em, ec, nvalid;
      logic [C*B-1:0] ti;
      logic [C*V-1:0] tv;

      repeat (3) @(negedge clk);
      chk("rst.mix", int'(mix), 14'h2000);
      chk("rst.valid", int'(mix_valid), 0);
      chk("rst.clip", int'(clip), 0);
      chk("rst.busy", int'(busy), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      do_sample("silence", {C{14'h2000}}, {C{8'd255}}, '0, 1'b0);
      do_sample("half", {14'h2000, 14'h2000, 14'h2000, 14'h3000}, {C{8'd255}} & ~32'hFF | 32'd128, '0, 1'b0);
      do_sample("sat_hi", {C{14'h3FFF}}, {C{8'd255}}, '0, 1'b0);
      do_sample("sat_lo", {C{14'h0000}}, {C{8'd255}}, '0, 1'b0);
      do_sample("floor", {14'h2000, 14'h2000, 14'h2000, 14'h1FFF}, 32'd1, '0, 1'b0);
      do_sample("mute", {14'h2000, 14'h2000, 14'h2000, 14'h1FFF}, 32'd1, 4'b0001, 1'b0);
      do_sample("busy_snap", rnd_in(), rnd_vol(), '0, 1'b1);

      // Reset during accumulation: no valid for the aborted sample.
      @(negedge clk);
      in_v = {C{14'h3FFF}}; vol_v = {C{8'd255}}; mute_v = '0;
      sample_clock = 1'b1;
      nvalid = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (mix_valid) nvalid++;
         if (k == 1) sample_clock = 1'b0;
         if (k == 3) rst = 1'b1;
         if (k == 4) begin
            rst = 1'b0;
            chk("abort.mix", int'(mix), 14'h2000);
            chk("abort.busy", int'(busy), 0);
         end
      end
      chk("abort.nvalid", nvalid, 0);
      chk("abort.clip", int'(clip), 0);
      do_sample("after_abort", rnd_in(), rnd_vol(), C'($urandom), 1'b0);

      // sample_clock held high across reset release: exactly one start.
      ti = rnd_in(); tv = rnd_vol();
      model(ti, tv, '0, em, ec);
      @(negedge clk);
      in_v = ti; vol_v = tv; mute_v = '0;
      sample_clock = 1'b1; rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      nvalid = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (mix_valid) begin
            nvalid++;
            chk("held.mix", int'(mix), em);
         end
      end
      chk("held.nvalid", nvalid, 1);
      sample_clock = 1'b0;
      repeat (2) @(negedge clk);

      for (int t = 0; t < 40; t++)
         do_sample($sformatf("rnd%0d", t), rnd_in(), rnd_vol(), C'($urandom & $urandom),
                   ($urandom_range(0, 3) == 0));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
